// File: rtl/freq_disp_pkg.sv
// Shared constants for the frequency display: digit count, converter state
// encodings and the active-high 7-segment table.
package freq_disp_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BIN_W      = 20;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int              SHIFT_CYCLES = BIN_W;
    localparam logic [BIN_W-1:0] SAT_LIMIT   = 20'd999999;
    localparam logic [BCD_W-1:0] BCD_SAT     = 24'h999999;

    // Patterns are gfedcba, active-high; element 0 is the rightmost entry.
    localparam logic [6:0]      SEG_BLANK = 7'b0000000;
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
        7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic blank);
        if (blank || digit > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/freq_display_if.sv
// Signal bundle of the frequency display: the counter-side input and the
// display-side outputs, with master (source) and slave (display) views.
interface freq_display_if;
    import freq_disp_pkg::*;

    logic [BIN_W-1:0]      freq;
    logic [7:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic [BCD_W-1:0]      bcd;
    logic                  busy;
    logic                  ovf;

    modport master (output freq, input seg, an, bcd, busy, ovf);
    modport slave  (input freq, output seg, an, bcd, busy, ovf);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 20-bit binary to six BCD digits with
// saturation at 999999; bcd/ovf change only in DONE.
module bin2bcd_seq
    import freq_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf
);

    localparam int SH_W = BCD_W + BIN_W;

    logic [1:0]      state_q, state_d;
    logic [SH_W-1:0] sh_q, sh_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            sat_q, sat_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] adj;
        adj = sh;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[BIN_W+4*i +: 4] >= 4'd5) begin
                adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
            end
        end
        return {adj[SH_W-2:0], 1'b0};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sh_d    = {{BCD_W{1'b0}}, bin};
                sat_d   = (bin > SAT_LIMIT);
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_d  = dabble_step(sh_q);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(SHIFT_CYCLES - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d   = sat_q ? BCD_SAT : sh_q[SH_W-1:BIN_W];
                ovf_d   = sat_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only.
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/freq_display.sv
// Six-digit multiplexed 7-segment frequency display with binary-to-BCD
// conversion; define FREQ_DISPLAY_LZB_EN to blank leading zeros.
module freq_display
    import freq_disp_pkg::*;
#(
    parameter int CLK_HZ         = 125000000,
    parameter int SCAN_HZ        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      freq,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [BCD_W-1:0]      bcd,
    output logic                  busy,
    output logic                  ovf
);

    localparam int PRESCALE_RAW = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
    localparam int PRESCALE     = (PRESCALE_RAW > 0) ? PRESCALE_RAW : 1;
    localparam int PRE_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(PRESCALE - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = SEG_ACTIVE_LOW ? '1 : '0;

    logic [BIN_W-1:0]      freq_s_q, freq_s_d;
    logic                  first_q, first_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [2:0]            digit_q, digit_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  conv_start, conv_busy, conv_done, conv_ovf;
    logic [BCD_W-1:0]      conv_bcd;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [3:0]            cur_nib;
    logic                  cur_blank;

    // The post-reset conversion stays pending until it actually completes.
    assign conv_start = !conv_busy && (first_q || (freq != freq_s_q));
    assign freq_s_d   = conv_start ? freq : freq_s_q;
    assign first_d    = first_q && !conv_done;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (freq_s_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    assign presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
    assign digit_d = (presc_q != PRE_MAX)    ? digit_q :
                     (digit_q == LAST_DIGIT) ? 3'd0    : digit_q + 3'd1;

`ifdef FREQ_DISPLAY_LZB_EN
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (conv_bcd[4*i +: 4] == 4'd0);
            blank_vec[i] = zero_run;
        end
    end
`else
    assign blank_vec = '0;
`endif

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == 3'(i)) begin
                cur_nib   = conv_bcd[4*i +: 4];
                cur_blank = blank_vec[i];
            end
        end
    end

    always_comb begin
        logic [7:0]            seg_ah;
        logic [NUM_DIGITS-1:0] an_ah;
        seg_ah = {conv_ovf && (digit_q == 3'd0), seg_decode(cur_nib, cur_blank)};
        an_ah  = NUM_DIGITS'(1) << digit_q;
        seg_d  = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
        an_d   = SEG_ACTIVE_LOW ? ~an_ah  : an_ah;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_s_q <= '0;
            first_q  <= 1'b1;
            presc_q  <= '0;
            digit_q  <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
        end else begin
            freq_s_q <= freq_s_d;
            first_q  <= first_d;
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign bcd  = conv_bcd;
    assign busy = conv_busy;
    assign ovf  = conv_ovf;

endmodule

// File: tb/tb_freq_display.sv
// Directed bench for freq_display (CLK_HZ=6000, SCAN_HZ=100, active-low
// drive); expected digit patterns follow FREQ_DISPLAY_LZB_EN.
module tb_freq_display;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_display_if fd_if ();

    freq_display #(
        .CLK_HZ         (6000),
        .SCAN_HZ        (100),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .freq (fd_if.freq),
        .seg  (fd_if.seg),
        .an   (fd_if.an),
        .bcd  (fd_if.bcd),
        .busy (fd_if.busy),
        .ovf  (fd_if.ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] seg_seen [6];

    // Active-low segment bytes {dp,g..a} for the digits used below.
    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
    localparam logic [7:0] S4 = 8'h99, S5 = 8'h92, S9 = 8'h90, S9DP = 8'h10;
    localparam logic [7:0] SBL = 8'hFF;
`ifdef FREQ_DISPLAY_LZB_EN
    localparam logic [7:0] LEAD = SBL;
`else
    localparam logic [7:0] LEAD = S0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_conv(input string tag, output int cycles, output int glitches);
        int guard = 0;
        logic [23:0] held;
        cycles   = 0;
        glitches = 0;
        while (fd_if.busy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_busy_rise"}, 32'(fd_if.busy), 32'd1);
        held = fd_if.bcd;
        while (fd_if.busy === 1'b1 && cycles < 100) begin
            if (fd_if.bcd !== held) glitches++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic scan_capture(input string tag);
        int prev = -1;
        int run = 0;
        int runs = 0;
        int bad_hot = 0;
        int bad_len = 0;
        int bad_ord = 0;
        int idx;
        logic [5:0] act;
        for (int i = 0; i < 6; i++) seg_seen[i] = 'x;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            act = ~fd_if.an;
            idx = -1;
            for (int i = 0; i < 6; i++) if (act == 6'(1 << i)) idx = i;
            if (idx < 0) begin
                bad_hot++;
            end else begin
                seg_seen[idx] = fd_if.seg;
                if (idx == prev) begin
                    run++;
                end else begin
                    if (prev >= 0) begin
                        if (idx != (prev + 1) % 6) bad_ord++;
                        if (runs > 0 && run != 10) bad_len++;
                        runs++;
                    end
                    prev = idx;
                    run  = 1;
                end
            end
        end
        check({tag, "_an_onehot"}, 32'(bad_hot), 32'd0);
        check({tag, "_an_runlen"}, 32'(bad_len), 32'd0);
        check({tag, "_an_order"},  32'(bad_ord), 32'd0);
        check({tag, "_runs_ge6"},  32'(runs >= 6), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, gl;

        fd_if.freq = 20'd12345;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(fd_if.busy), 32'd0);
        check("rst_bcd",  32'(fd_if.bcd),  32'd0);
        check("rst_ovf",  32'(fd_if.ovf),  32'd0);
        check("rst_seg",  32'(fd_if.seg),  32'hFF);
        check("rst_an",   32'(fd_if.an),   32'h3F);

        // First conversion after reset starts on its own.
        rst = 1'b0;
        wait_conv("c12345", cyc, gl);
        check("c12345_busy_cycles", 32'(cyc), 32'd22);
        check("c12345_glitch", 32'(gl), 32'd0);
        check("c12345_bcd", 32'(fd_if.bcd), 32'h012345);
        check("c12345_ovf", 32'(fd_if.ovf), 32'd0);
        scan_capture("s12345");
        check("s12345_d0", 32'(seg_seen[0]), 32'(S5));
        check("s12345_d1", 32'(seg_seen[1]), 32'(S4));
        check("s12345_d2", 32'(seg_seen[2]), 32'(S3));
        check("s12345_d3", 32'(seg_seen[3]), 32'(S2));
        check("s12345_d4", 32'(seg_seen[4]), 32'(S1));
        check("s12345_d5", 32'(seg_seen[5]), 32'(LEAD));

        fd_if.freq = 20'd1048575;
        wait_conv("cmax", cyc, gl);
        check("cmax_busy_cycles", 32'(cyc), 32'd22);
        check("cmax_bcd", 32'(fd_if.bcd), 32'h999999);
        check("cmax_ovf", 32'(fd_if.ovf), 32'd1);
        scan_capture("smax");
        check("smax_d0_dp", 32'(seg_seen[0]), 32'(S9DP));
        check("smax_d5",    32'(seg_seen[5]), 32'(S9));

        fd_if.freq = 20'd999999;
        wait_conv("c999999", cyc, gl);
        check("c999999_bcd", 32'(fd_if.bcd), 32'h999999);
        check("c999999_ovf", 32'(fd_if.ovf), 32'd0);

        fd_if.freq = 20'd1000000;
        wait_conv("c1e6", cyc, gl);
        check("c1e6_bcd", 32'(fd_if.bcd), 32'h999999);
        check("c1e6_ovf", 32'(fd_if.ovf), 32'd1);

        // A change mid-conversion must wait for the next IDLE cycle.
        fd_if.freq = 20'd100;
        repeat (5) @(negedge clk);
        fd_if.freq = 20'd200;
        wait_conv("c100", cyc, gl);
        check("c100_glitch", 32'(gl), 32'd0);
        check("c100_bcd", 32'(fd_if.bcd), 32'h000100);
        check("c100_ovf", 32'(fd_if.ovf), 32'd0);
        wait_conv("c200", cyc, gl);
        check("c200_busy_cycles", 32'(cyc), 32'd22);
        check("c200_glitch", 32'(gl), 32'd0);
        check("c200_bcd", 32'(fd_if.bcd), 32'h000200);

        fd_if.freq = 20'd42;
        wait_conv("c42", cyc, gl);
        check("c42_bcd", 32'(fd_if.bcd), 32'h000042);
        scan_capture("s42");
        check("s42_d0", 32'(seg_seen[0]), 32'(S2));
        check("s42_d1", 32'(seg_seen[1]), 32'(S4));
        check("s42_d2", 32'(seg_seen[2]), 32'(LEAD));
        check("s42_d3", 32'(seg_seen[3]), 32'(LEAD));
        check("s42_d4", 32'(seg_seen[4]), 32'(LEAD));
        check("s42_d5", 32'(seg_seen[5]), 32'(LEAD));

        // Reset partway through the SHIFT phase aborts the conversion.
        fd_if.freq = 20'd777;
        @(negedge clk);
        check("abort_busy_rise", 32'(fd_if.busy), 32'd1);
        repeat (11) @(negedge clk);
        check("abort_in_shift", 32'(fd_if.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(fd_if.busy), 32'd0);
        check("abort_bcd",  32'(fd_if.bcd),  32'd0);
        check("abort_ovf",  32'(fd_if.ovf),  32'd0);
        check("abort_seg",  32'(fd_if.seg),  32'hFF);
        check("abort_an",   32'(fd_if.an),   32'h3F);
        rst = 1'b0;
        wait_conv("c777", cyc, gl);
        check("c777_busy_cycles", 32'(cyc), 32'd22);
        check("c777_glitch", 32'(gl), 32'd0);
        check("c777_bcd", 32'(fd_if.bcd), 32'h000777);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
